// File: rtl/rx_port_arbiter_if.sv
// rx_port_arbiter_if
//   Bundles the RX-port side handshake, the packet-memory write port and the
//   per-frame report of rx_port_arbiter.
//   master : arbiter side (samples port/memory inputs, drives grant, writes, report)
//   slave  : environment side (RX MAC buffers, packet memory, frame accounting)
//   Signals:
//     port_req_i/valid_i/last_i/error_i [NUM_PORTS]  per-port frame pending / head word status
//     port_data_i [NUM_PORTS*DATA_WIDTH]             head word per port, port 0 in the LSBs
//     port_ready_o [NUM_PORTS]                       pop strobe for the granted head word
//     mem_wr_ready_i                                 memory accepts a write next cycle
//     mem_wr_en/data/last/abort/port_o               registered memory write port
//     frame_done/len/err_o                           committed-frame report
//     busy_o                                         arbiter not idle
interface rx_port_arbiter_if #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_WORDS = 1522,
    parameter int LEN_W           = $clog2(MAX_FRAME_WORDS + 1),
    parameter int PORT_W          = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0]            port_req_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] port_data_i;
    logic [NUM_PORTS-1:0]            port_valid_i;
    logic [NUM_PORTS-1:0]            port_last_i;
    logic [NUM_PORTS-1:0]            port_error_i;
    logic [NUM_PORTS-1:0]            port_ready_o;
    logic                            mem_wr_ready_i;
    logic                            mem_wr_en_o;
    logic [DATA_WIDTH-1:0]           mem_wr_data_o;
    logic                            mem_wr_last_o;
    logic                            mem_wr_abort_o;
    logic [PORT_W-1:0]               mem_wr_port_o;
    logic                            frame_done_o;
    logic [LEN_W-1:0]                frame_len_o;
    logic                            frame_err_o;
    logic                            busy_o;

    modport master (
        input  port_req_i, port_data_i, port_valid_i, port_last_i, port_error_i,
        input  mem_wr_ready_i,
        output port_ready_o,
        output mem_wr_en_o, mem_wr_data_o, mem_wr_last_o, mem_wr_abort_o, mem_wr_port_o,
        output frame_done_o, frame_len_o, frame_err_o, busy_o
    );

    modport slave (
        output port_req_i, port_data_i, port_valid_i, port_last_i, port_error_i,
        output mem_wr_ready_i,
        input  port_ready_o,
        input  mem_wr_en_o, mem_wr_data_o, mem_wr_last_o, mem_wr_abort_o, mem_wr_port_o,
        input  frame_done_o, frame_len_o, frame_err_o, busy_o
    );
endinterface

// File: rtl/rx_port_arbiter.sv
// rx_port_arbiter
//   Packet-atomic round-robin arbiter moving complete frames from the RX port
//   buffers into the shared packet-memory write port, one word per cycle.
//   Enforces a maximum frame length (abort + drain) and an idle timeout (abort).
//   Ports:
//     switch_clk  switch clock
//     switch_rst  asynchronous active-high reset
//     bus         rx_port_arbiter_if.master (port handshake, memory write, frame report)
//
//   state | meaning
//   IDLE  | waiting for any port_req_i, picks next port after rr_ptr
//   GRANT | one cycle: clear counters, move rr_ptr to the granted port
//   XFER  | copy granted port's words to memory, watch length and timeout
//   DRAIN | oversize frame aborted: pop remaining words without writing
module rx_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_FRAME_WORDS = 1522,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int LEN_W           = $clog2(MAX_FRAME_WORDS + 1)
) (
    input  logic              switch_clk,
    input  logic              switch_rst,
    rx_port_arbiter_if.master bus
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, DRAIN} state_t;

    state_t                  state_q;
    logic [PORT_W-1:0]       grant_q;
    logic [PORT_W-1:0]       rr_ptr_q;
    logic [LEN_W-1:0]        word_cnt_q;
    logic [LEN_W-1:0]        word_cnt_d;
    logic [TO_W-1:0]         to_cnt_q;

    logic                    mem_wr_en_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;
    logic                    mem_wr_last_q;
    logic                    mem_wr_abort_q;
    logic [PORT_W-1:0]       mem_wr_port_q;
    logic                    frame_done_q;
    logic [LEN_W-1:0]        frame_len_q;
    logic                    frame_err_q;
    logic                    busy_q;

    logic [PORT_W-1:0]       pick;
    logic [PORT_W-1:0]       idx;
    logic                    pick_vld;
    logic                    head_valid;
    logic                    head_last;
    logic                    head_err;
    logic [DATA_WIDTH-1:0]   head_data;
    logic                    at_max;
    logic                    xfer_accept;
    logic                    drain_accept;
    logic [NUM_PORTS-1:0]    port_ready;

    // Scan downward so the port closest after rr_ptr is assigned last and wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
            if (bus.port_req_i[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        head_valid = 1'b0;
        head_last  = 1'b0;
        head_err   = 1'b0;
        head_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == PORT_W'(p)) begin
                head_valid = bus.port_valid_i[p];
                head_last  = bus.port_last_i[p];
                head_err   = bus.port_error_i[p];
                head_data  = bus.port_data_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Once the counter is full the next cycle is spent issuing the abort, so no
    // further word may be accepted into memory.
    assign at_max       = (word_cnt_q == LEN_W'(MAX_FRAME_WORDS));
    assign word_cnt_d   = at_max ? word_cnt_q : word_cnt_q + LEN_W'(1);
    assign xfer_accept  = (state_q == XFER) && head_valid && bus.mem_wr_ready_i && !at_max;
    assign drain_accept = (state_q == DRAIN) && head_valid;

    always_comb begin
        port_ready = '0;
        if (xfer_accept || drain_accept) begin
            port_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge switch_clk or posedge switch_rst) begin
        if (switch_rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            rr_ptr_q       <= PORT_W'(NUM_PORTS - 1);
            word_cnt_q     <= '0;
            to_cnt_q       <= '0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_data_q  <= '0;
            mem_wr_last_q  <= 1'b0;
            mem_wr_abort_q <= 1'b0;
            mem_wr_port_q  <= '0;
            frame_done_q   <= 1'b0;
            frame_len_q    <= '0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            mem_wr_en_q    <= 1'b0;
            mem_wr_last_q  <= 1'b0;
            mem_wr_abort_q <= 1'b0;
            frame_done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q <= pick;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    word_cnt_q <= '0;
                    to_cnt_q   <= TO_W'(TIMEOUT_CYCLES);
                    rr_ptr_q   <= grant_q;
                    state_q    <= XFER;
                end
                XFER: begin
                    if (xfer_accept) begin
                        mem_wr_en_q   <= 1'b1;
                        mem_wr_data_q <= head_data;
                        mem_wr_last_q <= head_last;
                        mem_wr_port_q <= grant_q;
                        word_cnt_q    <= word_cnt_d;
                        to_cnt_q      <= TO_W'(TIMEOUT_CYCLES);
                        if (head_last) begin
                            frame_done_q <= 1'b1;
                            frame_len_q  <= word_cnt_d;
                            frame_err_q  <= head_err;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end else if (at_max) begin
                        mem_wr_abort_q <= 1'b1;
                        state_q        <= DRAIN;
                    end else if (!head_valid) begin
                        // Down-counter: terminal count reached on this idle cycle.
                        if (to_cnt_q <= TO_W'(1)) begin
                            mem_wr_abort_q <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q - TO_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_accept && head_last) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.port_ready_o   = port_ready;
    assign bus.mem_wr_en_o    = mem_wr_en_q;
    assign bus.mem_wr_data_o  = mem_wr_data_q;
    assign bus.mem_wr_last_o  = mem_wr_last_q;
    assign bus.mem_wr_abort_o = mem_wr_abort_q;
    assign bus.mem_wr_port_o  = mem_wr_port_q;
    assign bus.frame_done_o   = frame_done_q;
    assign bus.frame_len_o    = frame_len_q;
    assign bus.frame_err_o    = frame_err_q;
    assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_rx_port_arbiter.sv
module tb_rx_port_arbiter;
    localparam int NP   = 4;
    localparam int DW   = 8;
    localparam int MAXW = 1522;
    localparam int TO   = 64;
    localparam int LW   = $clog2(MAXW + 1);

    logic switch_clk = 1'b0;
    logic switch_rst = 1'b1;
    always #5 switch_clk = ~switch_clk;

    rx_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_FRAME_WORDS(MAXW)) bus_if ();

    rx_port_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_FRAME_WORDS(MAXW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .switch_clk(switch_clk),
        .switch_rst(switch_rst),
        .bus(bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // port buffers: {err, last, data}
    logic [9:0]  pq [NP][$];
    int          wcnt [NP];
    logic [10:0] exp_wr[$];     // {port, last, data}
    logic [11:0] exp_done[$];   // {len, err}
    int          order_q[$];
    int          exp_aborts = 0, got_aborts = 0, n_wr = 0, n_done = 0;
    int          cyc = 0, req_cyc = 0, first_wr_cyc = -1, last_wr_cyc = -1;
    int          abort_cyc = -1, last_pop_cyc = -1;
    bit          in_frame = 0, bp_mode = 0, bp_chk = 0, gap_chk = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic load_frame(input int p, input int n, input bit err, input int base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            pq[p].push_back({(with_last && i == n-1) ? err : 1'b0,
                             (with_last && i == n-1), 8'(base + i)});
        end
    endtask

    task automatic drive();
        logic [NP-1:0]    req, lst, err;
        logic [NP*DW-1:0] dat;
        logic [9:0]       h;
        req = '0; lst = '0; err = '0; dat = '0;
        for (int p = 0; p < NP; p++) begin
            if (pq[p].size() > 0) begin
                h = pq[p][0];
                req[p] = 1'b1;
                lst[p] = h[8];
                err[p] = h[9];
                dat[p*DW +: DW] = h[7:0];
            end
        end
        bus_if.port_req_i     = req;
        bus_if.port_valid_i   = req;
        bus_if.port_last_i    = lst;
        bus_if.port_error_i   = err;
        bus_if.port_data_i    = dat;
        bus_if.mem_wr_ready_i = bp_mode ? ~bus_if.mem_wr_ready_i : 1'b1;
    endtask

    task automatic monitor();
        logic [10:0] w;
        logic [11:0] d;
        if (bus_if.mem_wr_en_o) begin
            n_wr++;
            if (exp_wr.size() == 0) check_val("wr_unexpected", 32'(exp_wr.size()), 1);
            else begin
                w = exp_wr.pop_front();
                check_val("wr_word", {bus_if.mem_wr_port_o, bus_if.mem_wr_last_o, bus_if.mem_wr_data_o}, w);
            end
            if (!in_frame) begin
                order_q.push_back(int'(bus_if.mem_wr_port_o));
                if (gap_chk && last_wr_cyc >= 0) check_val("b2b_gap", cyc - last_wr_cyc, 3);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                in_frame = 1;
            end
            if (bus_if.mem_wr_last_o) in_frame = 0;
            last_wr_cyc = cyc;
        end
        if (bus_if.frame_done_o) begin
            n_done++;
            if (exp_done.size() == 0) check_val("done_unexpected", 32'(exp_done.size()), 1);
            else begin
                d = exp_done.pop_front();
                check_val("done_len_err", {bus_if.frame_len_o, bus_if.frame_err_o}, d);
            end
            check_val("done_with_last", {bus_if.mem_wr_en_o, bus_if.mem_wr_last_o}, 2'b11);
        end
        if (bus_if.mem_wr_abort_o) begin
            got_aborts++;
            abort_cyc = cyc;
            in_frame  = 0;
            check_val("abort_no_wr", bus_if.mem_wr_en_o, 0);
        end
    endtask

    task automatic sample_pops();
        logic [9:0] w;
        if (bp_chk && !bus_if.mem_wr_ready_i) check_val("bp_no_ready", bus_if.port_ready_o, 0);
        for (int p = 0; p < NP; p++) begin
            if (bus_if.port_ready_o[p]) begin
                if (pq[p].size() == 0) check_val("pop_empty", 32'(pq[p].size()), 1);
                else begin
                    w = pq[p].pop_front();
                    wcnt[p]++;
                    last_pop_cyc = cyc;
                    if (wcnt[p] <= MAXW) exp_wr.push_back({2'(p), w[8], w[7:0]});
                    if (w[8]) begin
                        if (wcnt[p] <= MAXW) exp_done.push_back({LW'(wcnt[p]), w[9]});
                        wcnt[p] = 0;
                    end else if (wcnt[p] == MAXW) begin
                        exp_aborts++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge switch_clk);
        cyc++;
        monitor();
        drive();
        #1;
        sample_pops();
    endtask

    function automatic bit all_idle();
        bit e = 1;
        for (int p = 0; p < NP; p++) if (pq[p].size() != 0) e = 0;
        return e && exp_wr.size() == 0 && exp_done.size() == 0 && !bus_if.busy_o;
    endfunction

    task automatic run_idle(input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!all_idle() && n < budget);
        check_val({tag, "_bound"}, 32'(all_idle()), 1);
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            pq[p].delete();
            wcnt[p] = 0;
        end
        exp_wr.delete();
        exp_done.delete();
        in_frame = 0;
    endtask

    function automatic logic [31:0] out_bundle();
        return {bus_if.busy_o, bus_if.mem_wr_en_o, bus_if.mem_wr_last_o, bus_if.mem_wr_abort_o,
                bus_if.frame_done_o, bus_if.frame_err_o, bus_if.port_ready_o, bus_if.mem_wr_port_o,
                bus_if.mem_wr_data_o, bus_if.frame_len_o};
    endfunction

    task automatic do_reset();
        switch_rst = 1'b1;
        clear_model();
        drive();
        repeat (2) @(negedge switch_clk);
        check_val("rst_outputs", out_bundle(), 0);
        switch_rst = 1'b0;
    endtask

    localparam int RR_EXP [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        int a0, w0, d0, n;
        bus_if.mem_wr_ready_i = 1'b1;
        do_reset();

        // single 64-word frame on port 2
        load_frame(2, 64, 1'b0, 8'h40, 1'b1);
        w0 = n_wr; d0 = n_done; first_wr_cyc = -1; order_q.delete();
        step();
        req_cyc = cyc;
        step();
        check_val("grant_busy", bus_if.busy_o, 1);
        run_idle(200, "single");
        check_val("first_wr_lat", first_wr_cyc - req_cyc, 3);
        check_val("single_writes", n_wr - w0, 64);
        check_val("single_done", n_done - d0, 1);
        check_val("single_port", order_q.size() > 0 ? order_q[0] : -1, 2);

        // round-robin with three continuously requesting ports
        do_reset();
        order_q.delete();
        for (int k = 0; k < 2; k++) begin
            load_frame(0, 10, 1'b0, 8'h00 + 16*k, 1'b1);
            load_frame(1, 10, 1'b0, 8'h40 + 16*k, 1'b1);
            load_frame(3, 10, 1'b0, 8'hC0 + 16*k, 1'b1);
        end
        last_wr_cyc = -1; gap_chk = 1;
        run_idle(300, "rr");
        gap_chk = 0;
        check_val("rr_frames", order_q.size(), 6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) check_val("rr_order", order_q[i], RR_EXP[i]);

        // backpressure: ready toggles every cycle
        bp_mode = 1; bp_chk = 1;
        d0 = n_done; w0 = n_wr;
        load_frame(1, 20, 1'b0, 8'h80, 1'b1);
        run_idle(200, "bp");
        bp_mode = 0; bp_chk = 0;
        bus_if.mem_wr_ready_i = 1'b1;
        check_val("bp_writes", n_wr - w0, 20);
        check_val("bp_done", n_done - d0, 1);
        check_val("bp_no_abort", got_aborts, exp_aborts);

        // oversize frame, then a normal frame from another port
        a0 = got_aborts; w0 = n_wr; d0 = n_done;
        load_frame(0, 1600, 1'b0, 8'h00, 1'b1);
        run_idle(2000, "ovs");
        check_val("ovs_writes", n_wr - w0, MAXW);
        check_val("ovs_abort", got_aborts - a0, 1);
        check_val("ovs_abort_exp", got_aborts, exp_aborts);
        check_val("ovs_abort_lat", abort_cyc - last_wr_cyc, 1);
        check_val("ovs_no_done", n_done - d0, 0);
        load_frame(3, 3, 1'b0, 8'h33, 1'b1);
        run_idle(50, "post_ovs");
        check_val("post_ovs_done", n_done - d0, 1);

        // timeout after 5 words
        a0 = got_aborts; d0 = n_done;
        load_frame(1, 5, 1'b0, 8'h55, 1'b0);
        exp_aborts++;
        n = 0;
        while (got_aborts == a0 && n < 200) begin
            step();
            n++;
        end
        check_val("to_abort_seen", got_aborts - a0, 1);
        check_val("to_abort_lat", abort_cyc - last_pop_cyc, TO + 1);
        check_val("to_busy_at_abort", bus_if.busy_o, 0);
        step();
        check_val("to_busy_next", bus_if.busy_o, 0);
        check_val("to_no_done", n_done - d0, 0);
        wcnt[1] = 0;
        check_val("to_abort_exp", got_aborts, exp_aborts);

        // errored frame
        d0 = n_done;
        load_frame(2, 4, 1'b1, 8'hE0, 1'b1);
        run_idle(50, "err");
        check_val("err_done", n_done - d0, 1);

        // asynchronous reset mid-frame, then port 0 has priority
        load_frame(1, 30, 1'b0, 8'h10, 1'b1);
        repeat (10) step();
        check_val("pre_rst_busy", bus_if.busy_o, 1);
        switch_rst = 1'b1;
        #1;
        check_val("rst_mid", out_bundle(), 0);
        clear_model();
        drive();
        @(negedge switch_clk);
        switch_rst = 1'b0;
        order_q.delete();
        load_frame(2, 2, 1'b0, 8'hA0, 1'b1);
        load_frame(0, 2, 1'b0, 8'hB0, 1'b1);
        run_idle(50, "post_rst");
        check_val("post_rst_frames", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check_val("post_rst_first", order_q[0], 0);
            check_val("post_rst_second", order_q[1], 2);
        end

        check_val("sb_empty", 32'(exp_wr.size() + exp_done.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule
